regsel_pipe: RTL and testbench
==============================

REGSEL_PIPE -- requirements
Module: regsel_pipe

Interface
REQ-001 The block SHALL have parameter NREGS, default 8, number of registers; power of two, 2..64.
REQ-002 The block SHALL have parameter NOPS, default 3, number of instruction operand fields; 1..7.
REQ-003 The block SHALL define derived constants AW = log2(NREGS), the index width, and SW = clog2(NOPS+1), the source-select width.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 notReset  in  1  reset; asynchronous and active-low.
REQ-006 opLatch  in  1  capture op into the internal operand register.
REQ-007 op  in  NOPS*AW  packed operand fields; field k occupies bits [k*AW +: AW].
REQ-008 oe, load  in  1 each  request an output-enable / a load strobe.
REQ-009 oeSourceSel, loadSourceSel  in  SW each  index source: 0 = microcode field, k = latched operand k-1.
REQ-010 useqRegSelOE, useqRegSelLoad  in  AW each  microcode register indices.
REQ-011 burstStart  in  1  start a sequential OE burst.
REQ-012 burstFirst, burstLast  in  AW each  burst range bounds.
REQ-013 burstBusy  out  1  burst in progress.
REQ-014 burstDone  out  1  one-cycle pulse on the final burst cycle.
REQ-015 regNotOEs, regNotLoads  out  NREGS each  registered one-hot, active-low register enables.
REQ-016 conflict  out  1  OE/load target collision; present only with REGSEL_CONFLICT_CHECK_EN.

Function
REQ-017 When opLatch=1 at an edge, the operand register SHALL take op; selects in that same cycle SHALL use the previous operand register value.
REQ-018 Outputs SHALL be registered: inputs sampled at edge N SHALL be reflected on the outputs immediately after edge N (one-cycle latency).
REQ-019 With oe=1 and in IDLE, regNotOEs SHALL be ~(1<<index) for the source selected by oeSourceSel; oe=0 SHALL give all ones.
REQ-020 load/loadSourceSel SHALL drive regNotLoads identically and independently of the burst state.
REQ-021 A source select value >NOPS SHALL deassert that output (all ones).
REQ-022 The FSM SHALL have states IDLE and BURST.
REQ-023 In IDLE, burstStart=1 at an edge SHALL go to BURST, set idx=burstFirst and latch last=burstLast.
REQ-024 In BURST, regNotOEs SHALL be ~(1<<idx), overriding oe, and idx SHALL increment modulo NREGS each edge.
REQ-025 In BURST, the cycle whose outputs show idx==last SHALL also assert burstDone=1; the next edge SHALL return to IDLE.
REQ-026 Burst length SHALL be ((last-first) mod NREGS)+1 cycles; first>last SHALL wrap from NREGS-1 to 0; first==last SHALL give 1 cycle.
REQ-027 burstStart during BURST SHALL be ignored.
REQ-028 burstBusy SHALL be 1 in every cycle that a burst index is driven on regNotOEs.

Reset
REQ-029 When notReset=0, the block SHALL asynchronously force: regNotOEs and regNotLoads all ones, operand register 0, state IDLE, idx 0, burstBusy 0, burstDone 0, conflict 0.
REQ-030 Reset mid-burst SHALL abort the burst without a burstDone pulse.
REQ-031 The first rising edge after notReset rises SHALL operate normally.

Configuration
REQ-032 With REGSEL_CONFLICT_CHECK_EN defined, conflict SHALL be registered 1 when both outputs assert the same register in the same cycle; otherwise 0.
REQ-033 Without REGSEL_CONFLICT_CHECK_EN, the conflict port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-034 NREGS=8, oe=1, oeSourceSel=0, useqRegSelOE=5 -> regNotOEs=8'hDF one edge later; oe=0 -> 8'hFF.
REQ-035 op field1=3 with opLatch=1 at edge N, oeSourceSel=2, oe=1 at edges N and N+1 -> outputs after edge N use the old field, outputs after edge N+1 show 8'hF7.
REQ-036 burstStart, first=6, last=1 -> regNotOEs steps FF^40, FF^80, FF^01, FF^02 over 4 cycles; burstDone=1 only with FF^02; burstBusy=1 for those 4 cycles.
REQ-037 burstStart pulsed mid-burst -> no restart, length unchanged; load=1 with useqRegSelLoad=2 during the burst -> regNotLoads=8'hFB.
REQ-038 notReset=0 during burst cycle 2 -> outputs 8'hFF immediately, burstBusy=0, no burstDone; after release, a new burst with first=last=4 -> exactly 1 cycle of 8'hEF with burstDone=1.
REQ-039 With REGSEL_CONFLICT_CHECK_EN, oe and load both selecting register 3 -> conflict=1 alongside regNotOEs=regNotLoads=8'hF7; different registers -> conflict=0.

Source files
------------

// File: rtl/regsel_pipe.sv
// Register-select pipeline: registered one-hot active-low OE/load enables with a sequential OE burst.
// Define REGSEL_CONFLICT_CHECK_EN to add the registered OE/load collision output.
module regsel_pipe #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned NOPS  = 3,
  localparam int unsigned AW = $clog2(NREGS),
  localparam int unsigned SW = $clog2(NOPS + 1)
) (
  input  logic                 clock,
  input  logic                 notReset,
  input  logic                 opLatch,
  input  logic [NOPS*AW-1:0]   op,
  input  logic                 oe,
  input  logic                 load,
  input  logic [SW-1:0]        oeSourceSel,
  input  logic [SW-1:0]        loadSourceSel,
  input  logic [AW-1:0]        useqRegSelOE,
  input  logic [AW-1:0]        useqRegSelLoad,
  input  logic                 burstStart,
  input  logic [AW-1:0]        burstFirst,
  input  logic [AW-1:0]        burstLast,
  output logic                 burstBusy,
  output logic                 burstDone,
  output logic [NREGS-1:0]     regNotOEs,
  output logic [NREGS-1:0]     regNotLoads
`ifdef REGSEL_CONFLICT_CHECK_EN
  ,
  output logic                 conflict
`endif
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW-1:0]      last_q, last_d;
  logic [NOPS*AW-1:0] op_q;
  logic [NREGS-1:0]   oes_d, loads_d;
  logic               busy_d, done_d;

  // Source 0 is the microcode index, k picks latched operand field k-1, anything above NOPS is off.
  function automatic logic [NREGS-1:0] decode_n(input logic en, input logic [SW-1:0] sel,
                                                input logic [AW-1:0] useq,
                                                input logic [NOPS*AW-1:0] ops);
    logic [AW-1:0] idx;
    decode_n = '1;
    idx = useq;
    for (int unsigned k = 1; k <= NOPS; k++) begin
      if (32'(sel) == k) idx = ops[(k-1)*AW +: AW];
    end
    if (en && (32'(sel) <= NOPS)) decode_n[idx] = 1'b0;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    oes_d   = decode_n(oe, oeSourceSel, useqRegSelOE, op_q);
    loads_d = decode_n(load, loadSourceSel, useqRegSelLoad, op_q);
    unique case (state_q)
      StIdle: begin
        if (burstStart) begin
          state_d = StBurst;
          idx_d   = burstFirst;
          last_d  = burstLast;
          busy_d  = 1'b1;
          done_d  = (burstFirst == burstLast);
          oes_d   = '1;
          oes_d[burstFirst] = 1'b0;
        end
      end
      StBurst: begin
        // idx_q is the index currently on the outputs; reaching last ends the burst.
        if (idx_q == last_q) begin
          state_d = StIdle;
        end else begin
          idx_d  = idx_q + AW'(1);
          busy_d = 1'b1;
          done_d = (idx_d == last_q);
          oes_d  = '1;
          oes_d[idx_d] = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      last_q      <= '0;
      op_q        <= '0;
      regNotOEs   <= '1;
      regNotLoads <= '1;
      burstBusy   <= 1'b0;
      burstDone   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      if (opLatch) op_q <= op;
      regNotOEs   <= oes_d;
      regNotLoads <= loads_d;
      burstBusy   <= busy_d;
      burstDone   <= done_d;
    end
  end

`ifdef REGSEL_CONFLICT_CHECK_EN
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) conflict <= 1'b0;
    else           conflict <= |(~oes_d & ~loads_d);
  end
`endif

endmodule

// File: tb/tb_regsel_pipe.sv
// Directed self-checking bench for regsel_pipe (NREGS=8, NOPS=3).
// Conflict checks are compiled in when REGSEL_CONFLICT_CHECK_EN is defined.
module tb_regsel_pipe;
  localparam int unsigned NREGS = 8;
  localparam int unsigned NOPS  = 3;
  localparam int unsigned AW    = 3;
  localparam int unsigned SW    = 2;

  logic               clock = 1'b0;
  logic               notReset;
  logic               opLatch;
  logic [NOPS*AW-1:0] op;
  logic               oe, load;
  logic [SW-1:0]      oeSourceSel, loadSourceSel;
  logic [AW-1:0]      useqRegSelOE, useqRegSelLoad;
  logic               burstStart;
  logic [AW-1:0]      burstFirst, burstLast;
  logic               burstBusy, burstDone;
  logic [NREGS-1:0]   regNotOEs, regNotLoads;
`ifdef REGSEL_CONFLICT_CHECK_EN
  logic               conflict;
`endif

  int errors = 0;
  int checks = 0;

  regsel_pipe #(.NREGS(NREGS), .NOPS(NOPS)) dut (
    .clock(clock), .notReset(notReset), .opLatch(opLatch), .op(op),
    .oe(oe), .load(load), .oeSourceSel(oeSourceSel), .loadSourceSel(loadSourceSel),
    .useqRegSelOE(useqRegSelOE), .useqRegSelLoad(useqRegSelLoad),
    .burstStart(burstStart), .burstFirst(burstFirst), .burstLast(burstLast),
    .burstBusy(burstBusy), .burstDone(burstDone),
    .regNotOEs(regNotOEs), .regNotLoads(regNotLoads)
`ifdef REGSEL_CONFLICT_CHECK_EN
    , .conflict(conflict)
`endif
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    opLatch = 0; op = '0; oe = 0; load = 0; oeSourceSel = 0; loadSourceSel = 0;
    useqRegSelOE = 0; useqRegSelLoad = 0; burstStart = 0; burstFirst = 0; burstLast = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    oe = 1; load = 1; useqRegSelOE = 2; useqRegSelLoad = 3;
    notReset = 0;
    step(); step();
    checks++; if (regNotOEs !== 8'hFF) begin errors++; $display("FAIL reset_oes got %h want ff", regNotOEs); end
    checks++; if (regNotLoads !== 8'hFF) begin errors++; $display("FAIL reset_loads got %h want ff", regNotLoads); end
    checks++; if (burstBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", burstBusy); end
    checks++; if (burstDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", burstDone); end
`ifdef REGSEL_CONFLICT_CHECK_EN
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b want 0", conflict); end
`endif
    notReset = 1;
    idle_inputs();
    step();
  endtask

  task automatic test_microcode();
    oe = 1; oeSourceSel = 0; useqRegSelOE = 5;
    step();
    checks++; if (regNotOEs !== 8'hDF) begin errors++; $display("FAIL ucode_oe5 got %h want df", regNotOEs); end
    checks++; if (regNotLoads !== 8'hFF) begin errors++; $display("FAIL ucode_load_idle got %h want ff", regNotLoads); end
    oe = 0; load = 1; loadSourceSel = 0; useqRegSelLoad = 2;
    step();
    checks++; if (regNotOEs !== 8'hFF) begin errors++; $display("FAIL ucode_oe_off got %h want ff", regNotOEs); end
    checks++; if (regNotLoads !== 8'hFB) begin errors++; $display("FAIL ucode_load2 got %h want fb", regNotLoads); end
    idle_inputs();
    step();
  endtask

  task automatic test_operand();
    // fields: f0=1, f1=3, f2=6
    op = 9'((6 << 6) | (3 << 3) | 1); opLatch = 1; oe = 1; oeSourceSel = 2;
    step();
    checks++; if (regNotOEs !== 8'hFE) begin errors++; $display("FAIL op_old_field got %h want fe", regNotOEs); end
    opLatch = 0; op = '0;
    step();
    checks++; if (regNotOEs !== 8'hF7) begin errors++; $display("FAIL op_field1 got %h want f7", regNotOEs); end
    oeSourceSel = 1; load = 1; loadSourceSel = 3;
    step();
    checks++; if (regNotOEs !== 8'hFD) begin errors++; $display("FAIL op_field0 got %h want fd", regNotOEs); end
    checks++; if (regNotLoads !== 8'hBF) begin errors++; $display("FAIL op_load_field2 got %h want bf", regNotLoads); end
    idle_inputs();
    step();
  endtask

  task automatic test_burst_wrap();
    logic [7:0] exp_oes [4];
    logic       exp_done [4];
    exp_oes = '{8'hBF, 8'h7F, 8'hFE, 8'hFD};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1};
    burstStart = 1; burstFirst = 6; burstLast = 1;
    step();
    burstStart = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (regNotOEs !== exp_oes[i]) begin errors++; $display("FAIL wrap_oes[%0d] got %h want %h", i, regNotOEs, exp_oes[i]); end
      checks++; if (burstDone !== exp_done[i]) begin errors++; $display("FAIL wrap_done[%0d] got %b want %b", i, burstDone, exp_done[i]); end
      checks++; if (burstBusy !== 1'b1) begin errors++; $display("FAIL wrap_busy[%0d] got %b want 1", i, burstBusy); end
      step();
    end
    checks++; if (regNotOEs !== 8'hFF) begin errors++; $display("FAIL wrap_after_oes got %h want ff", regNotOEs); end
    checks++; if (burstBusy !== 1'b0) begin errors++; $display("FAIL wrap_after_busy got %b want 0", burstBusy); end
    checks++; if (burstDone !== 1'b0) begin errors++; $display("FAIL wrap_after_done got %b want 0", burstDone); end
    idle_inputs();
  endtask

  task automatic test_burst_ignore();
    oe = 1; oeSourceSel = 0; useqRegSelOE = 7;
    burstStart = 1; burstFirst = 0; burstLast = 2;
    step();
    checks++; if (regNotOEs !== 8'hFE) begin errors++; $display("FAIL ign_c0_oes got %h want fe", regNotOEs); end
    burstFirst = 5; burstLast = 5; load = 1; loadSourceSel = 0; useqRegSelLoad = 2;
    step();
    burstStart = 0;
    checks++; if (regNotOEs !== 8'hFD) begin errors++; $display("FAIL ign_c1_oes got %h want fd", regNotOEs); end
    checks++; if (regNotLoads !== 8'hFB) begin errors++; $display("FAIL ign_c1_loads got %h want fb", regNotLoads); end
    checks++; if (burstDone !== 1'b0) begin errors++; $display("FAIL ign_c1_done got %b want 0", burstDone); end
    step();
    checks++; if (regNotOEs !== 8'hFB) begin errors++; $display("FAIL ign_c2_oes got %h want fb", regNotOEs); end
    checks++; if (burstDone !== 1'b1) begin errors++; $display("FAIL ign_c2_done got %b want 1", burstDone); end
    step();
    checks++; if (regNotOEs !== 8'h7F) begin errors++; $display("FAIL ign_idle_oes got %h want 7f", regNotOEs); end
    checks++; if (burstBusy !== 1'b0) begin errors++; $display("FAIL ign_idle_busy got %b want 0", burstBusy); end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_burst();
    burstStart = 1; burstFirst = 0; burstLast = 5;
    step();
    burstStart = 0;
    step();
    checks++; if (regNotOEs !== 8'hFD) begin errors++; $display("FAIL rmb_c1_oes got %h want fd", regNotOEs); end
    #2 notReset = 0;
    #1;
    checks++; if (regNotOEs !== 8'hFF) begin errors++; $display("FAIL rmb_async_oes got %h want ff", regNotOEs); end
    checks++; if (burstBusy !== 1'b0) begin errors++; $display("FAIL rmb_async_busy got %b want 0", burstBusy); end
    checks++; if (burstDone !== 1'b0) begin errors++; $display("FAIL rmb_async_done got %b want 0", burstDone); end
    step();
    notReset = 1;
    step();
    checks++; if (burstBusy !== 1'b0) begin errors++; $display("FAIL rmb_post_busy got %b want 0", burstBusy); end
    checks++; if (burstDone !== 1'b0) begin errors++; $display("FAIL rmb_post_done got %b want 0", burstDone); end
    burstStart = 1; burstFirst = 4; burstLast = 4;
    step();
    burstStart = 0;
    checks++; if (regNotOEs !== 8'hEF) begin errors++; $display("FAIL one_oes got %h want ef", regNotOEs); end
    checks++; if (burstDone !== 1'b1) begin errors++; $display("FAIL one_done got %b want 1", burstDone); end
    checks++; if (burstBusy !== 1'b1) begin errors++; $display("FAIL one_busy got %b want 1", burstBusy); end
    step();
    checks++; if (regNotOEs !== 8'hFF) begin errors++; $display("FAIL one_after_oes got %h want ff", regNotOEs); end
    checks++; if (burstBusy !== 1'b0) begin errors++; $display("FAIL one_after_busy got %b want 0", burstBusy); end
    checks++; if (burstDone !== 1'b0) begin errors++; $display("FAIL one_after_done got %b want 0", burstDone); end
    idle_inputs();
  endtask

`ifdef REGSEL_CONFLICT_CHECK_EN
  task automatic test_conflict();
    oe = 1; load = 1; useqRegSelOE = 3; useqRegSelLoad = 3;
    step();
    checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL cf_same got %b want 1", conflict); end
    checks++; if (regNotOEs !== 8'hF7) begin errors++; $display("FAIL cf_same_oes got %h want f7", regNotOEs); end
    checks++; if (regNotLoads !== 8'hF7) begin errors++; $display("FAIL cf_same_loads got %h want f7", regNotLoads); end
    useqRegSelLoad = 4;
    step();
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL cf_diff got %b want 0", conflict); end
    checks++; if (regNotLoads !== 8'hEF) begin errors++; $display("FAIL cf_diff_loads got %h want ef", regNotLoads); end
    idle_inputs();
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_microcode();
    test_operand();
    test_burst_wrap();
    test_burst_ignore();
    test_reset_mid_burst();
`ifdef REGSEL_CONFLICT_CHECK_EN
    test_conflict();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
